// File: rtl/pa_ifu_ras_ckpt.sv
// Return address stack with a speculative top pointer and a committed checkpoint.
// On recover, the speculative pointer and count are restored from the committed ones in one cycle.
module pa_ifu_ras_ckpt #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 24,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             spec_push_vld,
   input  logic [PC_W-1:0]  spec_push_pc,
   input  logic             spec_pop_vld,
   input  logic             cmt_push_vld,
   input  logic             cmt_pop_vld,
   input  logic             recover,
   output logic [PC_W-1:0]  ras_tar_pc,
   output logic             ras_tar_vld,
   output logic [PTR_W:0]   ras_spec_cnt
);

   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [PC_W-1:0]  entry [DEPTH];
   logic [PTR_W-1:0] sp, cp, sp_upd, sp_nxt, cp_nxt;
   logic [PTR_W:0]   scnt, ccnt, scnt_upd, scnt_nxt, ccnt_nxt;

   // Returns {ptr, cnt}; a same-cycle push+pop behaves as pop followed by push.
   function automatic logic [2*PTR_W:0] upd(input logic [PTR_W-1:0] ptr,
                                            input logic [PTR_W:0]   cnt,
                                            input logic push,
                                            input logic pop);
      logic [PTR_W-1:0] p;
      logic [PTR_W:0]   c;
      p = ptr;
      c = cnt;
      if (push && pop) begin
         if (cnt == '0) begin
            p = ptr + PTR_ONE;
            c = CNT_ONE;
         end
      end else if (push) begin
         p = ptr + PTR_ONE;
         c = (cnt == CNT_FULL) ? cnt : cnt + CNT_ONE;
      end else if (pop) begin
         if (cnt != '0) begin
            p = ptr - PTR_ONE;
            c = cnt - CNT_ONE;
         end
      end
      return {p, c};
   endfunction

   always_comb begin
      {sp_upd, scnt_upd} = upd(sp, scnt, spec_push_vld, spec_pop_vld);
      {cp_nxt, ccnt_nxt} = upd(cp, ccnt, cmt_push_vld, cmt_pop_vld);
      sp_nxt   = recover ? cp_nxt   : sp_upd;
      scnt_nxt = recover ? ccnt_nxt : scnt_upd;
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         sp   <= '0;
         cp   <= '0;
         scnt <= '0;
         ccnt <= '0;
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else begin
         sp   <= sp_nxt;
         cp   <= cp_nxt;
         scnt <= scnt_nxt;
         ccnt <= ccnt_nxt;
         // Wrong-path entries are not undone by recover; the IU catches any resulting mispredict.
         if (spec_push_vld && !recover) entry[sp_upd] <= spec_push_pc;
      end
   end

   assign ras_tar_pc   = entry[sp];
   assign ras_tar_vld  = (scnt != '0);
   assign ras_spec_cnt = scnt;

endmodule
